// File: rtl/gc_evaluator_pkg.sv
// gc_evaluator_pkg: shared garbled-circuit constants, gate codes and AES round helpers
package gc_evaluator_pkg;

    localparam int NR_AES = 10;
    localparam int K_DEF  = 128;
    localparam int S_DEF  = 32;

    typedef enum logic [3:0] {
        NORGATE  = 4'b0001,
        NOTGATE  = 4'b0011,
        XORGATE  = 4'b0110,
        NANDGATE = 4'b0111,
        ANDGATE  = 4'b1000,
        XNORGATE = 4'b1001,
        ORGATE   = 4'b1110
    } gate_e;

    localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    // Free gates are evaluated without the garbled table.
    function automatic logic is_free(input logic [3:0] g);
        return g == XORGATE || g == XNORGATE || g == NOTGATE;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One AES round; state byte 0 is the most significant byte of the block.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [0:15][7:0] a, b, m;
        a = s;
        for (int i = 0; i < 16; i++) b[i] = SBOX[a[(i + 4 * (i % 4)) % 16]];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            m[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
        end
        return (last ? b : m) ^ rk;
    endfunction

endpackage

// File: rtl/gc_evaluator_hash.sv
// gc_evaluator_hash: two parallel pipelined fixed-key AES MMO hashes, H = AES(2W^t) ^ (2W^t)
module gc_evaluator_hash
    import gc_evaluator_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic                        clk,
    input  logic [128*(NR_AES+1)-1:0]   round_keys,
    input  logic [1:0][K-1:0]           w,
    input  logic [1:0][K-1:0]           t,
    output logic [1:0][K-1:0]           h
);

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [K-1:0] x;
        logic [NR_AES-1:0][K-1:0] s_q, x_q;
        assign x = (w[l] << 1) ^ t[l];
        // Rounds 0..NR_AES-1 are registered; the input block rides alongside for the feed-forward.
        always_ff @(posedge clk) begin
            s_q[0] <= x ^ round_keys[0 +: 128];
            x_q[0] <= x;
            for (int r = 1; r < NR_AES; r++) begin
                s_q[r] <= aes_round(s_q[r-1], round_keys[128*r +: 128], 1'b0);
                x_q[r] <= x_q[r-1];
            end
        end
        assign h[l] = aes_round(s_q[NR_AES-1], round_keys[128*NR_AES +: 128], 1'b1) ^ x_q[NR_AES-1];
    end

endmodule

// File: rtl/gc_evaluator.sv
// gc_evaluator: pipelined half-gate garbled-circuit evaluator; GC_EVAL_STATS_EN adds free/table gate counters
module gc_evaluator
    import gc_evaluator_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int S = S_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [128*(NR_AES+1)-1:0]   AES_expandedKey,
    input  logic [S-1:0]                cid,
    input  logic                        in_valid,
    input  logic [S-1:0]                gid,
    input  logic [3:0]                  g_logic,
    input  logic [K-1:0]                in0_label,
    input  logic [K-1:0]                in1_label,
    input  logic [K-1:0]                gt_row_0,
    input  logic [K-1:0]                gt_row_1,
    output logic                        out_valid,
    output logic [S-1:0]                out_gid,
    output logic [K-1:0]                out_label
`ifdef GC_EVAL_STATS_EN
    ,
    output logic [31:0]                 free_count,
    output logic [31:0]                 table_count
`endif
);

    localparam int L = NR_AES - 1;

    logic [K-1:0] t0, t1, fres, tab;
    logic [1:0][K-1:0] h;
    logic fg;
    logic [NR_AES-1:0] v_q, f_q, sa_q, sb_q;
    logic [NR_AES-1:0][S-1:0] gid_q;
    logic [NR_AES-1:0][K-1:0] r0_q, r1_q, a_q, fr_q;

    assign t0   = {{(K-2*S-1){1'b0}}, cid, gid, 1'b0};
    assign t1   = {{(K-2*S-1){1'b0}}, cid, gid, 1'b1};
    assign fg   = is_free(g_logic);
    assign fres = g_logic == NOTGATE ? in0_label : in0_label ^ in1_label;

    gc_evaluator_hash #(.K(K)) u_hash (
        .clk        (clk),
        .round_keys (AES_expandedKey),
        .w          ({in1_label, in0_label}),
        .t          ({t1, t0}),
        .h          (h)
    );

    // Valid bits are the only pipeline state that reset clears, so in-flight gates vanish.
    always_ff @(posedge clk) begin
        v_q <= rst ? '0 : {v_q[L-1:0], in_valid};
    end

    // Side-band delay line, one stage per registered AES round.
    always_ff @(posedge clk) begin
        f_q   <= {f_q[L-1:0], fg};
        sa_q  <= {sa_q[L-1:0], in0_label[0]};
        sb_q  <= {sb_q[L-1:0], in1_label[0]};
        gid_q <= {gid_q[L-1:0], gid};
        r0_q  <= {r0_q[L-1:0], gt_row_0};
        r1_q  <= {r1_q[L-1:0], gt_row_1};
        a_q   <= {a_q[L-1:0], in0_label};
        fr_q  <= {fr_q[L-1:0], fres};
    end

    assign tab = h[0] ^ h[1] ^ (sa_q[L] ? r0_q[L] : '0) ^ (sb_q[L] ? (r1_q[L] ^ a_q[L]) : '0);

    // Output register absorbs the last AES round and the half-gate combine; holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_gid   <= '0;
            out_label <= '0;
        end else begin
            out_valid <= v_q[L];
            out_gid   <= v_q[L] ? gid_q[L] : out_gid;
            out_label <= v_q[L] ? (f_q[L] ? fr_q[L] : tab) : out_label;
        end
    end

`ifdef GC_EVAL_STATS_EN
    // Saturating counts of emitted free and table gates.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_count  <= '0;
            table_count <= '0;
        end else begin
            free_count  <= (v_q[L] && f_q[L] && free_count != '1) ? free_count + 32'd1 : free_count;
            table_count <= (v_q[L] && !f_q[L] && table_count != '1) ? table_count + 32'd1 : table_count;
        end
    end
`endif

endmodule

// File: tb/tb_gc_evaluator.sv
// tb_gc_evaluator: randomized bench with a half-gate garbler and textbook AES reference model
module tb_gc_evaluator;
    import gc_evaluator_pkg::*;

    localparam int K = 128;
    localparam int S = 32;

    typedef struct {
        int           due;
        logic [127:0] lab;
        logic [31:0]  id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [128*(NR_AES+1)-1:0] aes_key;
    logic [S-1:0] cid, gid, out_gid;
    logic in_valid, out_valid;
    logic [3:0] g_logic;
    logic [K-1:0] in0_label, in1_label, gt_row_0, gt_row_1, out_label;
`ifdef GC_EVAL_STATS_EN
    logic [31:0] free_count, table_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int ec = 0;
    logic rst_s;
    exp_t q[$];
    exp_t e_m;
    logic [127:0] last_l;
    logic [31:0] last_g;
    logic [7:0] sb [256];
    logic [127:0] rk [11];
    logic [127:0] gr;

    gc_evaluator #(.K(K), .S(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .AES_expandedKey (aes_key),
        .cid             (cid),
        .in_valid        (in_valid),
        .gid             (gid),
        .g_logic         (g_logic),
        .in0_label       (in0_label),
        .in1_label       (in1_label),
        .gt_row_0        (gt_row_0),
        .gt_row_1        (gt_row_1),
        .out_valid       (out_valid),
        .out_gid         (out_gid),
        .out_label       (out_label)
`ifdef GC_EVAL_STATS_EN
        ,
        .free_count      (free_count),
        .table_count     (table_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ec    <= ec + 1;
        rst_s <= rst;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, ec, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from the field inverse and affine map rather than a table.
    function automatic void build_sbox();
        logic [7:0] y;
        for (int x = 0; x < 256; x++) begin
            y = 8'h01;
            for (int i = 0; i < 254; i++) y = gmul(y, 8'(x));
            if (x == 0) y = 8'h00;
            sb[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
        end
    endfunction

    function automatic void expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] mc [4];
        logic [127:0] res;
        mc = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sb[st[i]];
            for (int i = 0; i < 16; i++) st[i] = tmp[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int rr = 0; rr < 4; rr++) begin
                        tmp[4*c+rr] = 8'h00;
                        for (int k = 0; k < 4; k++) tmp[4*c+rr] = tmp[4*c+rr] ^ gmul(mc[(k - rr + 4) % 4], st[4*c+k]);
                    end
                for (int i = 0; i < 16; i++) st[i] = tmp[i];
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] hh(input logic [127:0] w, input logic [31:0] id, input logic b);
        logic [127:0] x;
        x = (w << 1) ^ {63'b0, cid, id, b};
        return aes_enc(x) ^ x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_raw(input logic [3:0] g, input logic [31:0] id, input logic [127:0] a, input logic [127:0] b,
                             input logic [127:0] r0, input logic [127:0] r1, input logic [127:0] want);
        exp_t e;
        in_valid  = 1'b1;
        g_logic   = g;
        gid       = id;
        in0_label = a;
        in1_label = b;
        gt_row_0  = r0;
        gt_row_1  = r1;
        e.due = ec + 1 + NR_AES;
        e.lab = want;
        e.id  = id;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Garbles the gate from zero labels a0/b0 and presents the labels for truth values a/b.
    task automatic drive_gate(input logic [3:0] g, input logic [31:0] id, input logic [127:0] a0, input logic [127:0] b0,
                              input logic a, input logic b);
        logic [127:0] aa, bb, ha0, ha1, hb0, hb1, tg, te, c0;
        aa = a ? a0 ^ gr : a0;
        bb = b ? b0 ^ gr : b0;
        if (is_free(g)) begin
            drive_raw(g, id, aa, bb, rnd128(), rnd128(), g == NOTGATE ? aa : aa ^ bb);
        end else begin
            ha0 = hh(a0, id, 1'b0);
            ha1 = hh(a0 ^ gr, id, 1'b0);
            hb0 = hh(b0, id, 1'b1);
            hb1 = hh(b0 ^ gr, id, 1'b1);
            tg  = ha0 ^ ha1 ^ (b0[0] ? gr : 128'h0);
            te  = hb0 ^ hb1 ^ a0;
            c0  = ha0 ^ (a0[0] ? tg : 128'h0) ^ hb0 ^ (b0[0] ? te ^ a0 : 128'h0);
            drive_raw(g, id, aa, bb, tg, te, (a & b) ? c0 ^ gr : c0);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every cycle the outputs must match either an emitted gate, a held value, or reset zeros.
    always @(negedge clk) begin
        if (ec > 0) begin
            if (rst_s) begin
                while (q.size() > 0 && q[0].due <= ec + NR_AES) void'(q.pop_front());
                last_l = '0;
                last_g = '0;
                check("rst_valid", 128'(out_valid), 128'(0));
                check("rst_gid", 128'(out_gid), 128'(0));
                check("rst_label", out_label, 128'(0));
            end else if (q.size() > 0 && q[0].due == ec) begin
                e_m = q.pop_front();
                last_l = e_m.lab;
                last_g = e_m.id;
                check("emit_valid", 128'(out_valid), 128'(1));
                check("emit_gid", 128'(out_gid), 128'(e_m.id));
                check("emit_label", out_label, e_m.lab);
            end else begin
                check("bubble_valid", 128'(out_valid), 128'(0));
                check("hold_gid", 128'(out_gid), 128'(last_g));
                check("hold_label", out_label, last_l);
            end
        end
    end

    logic [3:0] mix [11];
    logic [3:0] codes [7];
    logic [127:0] a0, b0;

    initial begin
        mix   = '{ANDGATE, XORGATE, ORGATE, NANDGATE, XNORGATE, ANDGATE, NOTGATE, NORGATE, ANDGATE, XORGATE, ORGATE};
        codes = '{ANDGATE, ORGATE, NANDGATE, NORGATE, XORGATE, XNORGATE, NOTGATE};
        rst = 1'b1;
        in_valid = 1'b0;
        cid = '0;
        gid = '0;
        g_logic = '0;
        in0_label = '0;
        in1_label = '0;
        gt_row_0 = '0;
        gt_row_1 = '0;
        build_sbox();
        expand(128'h000102030405060708090a0b0c0d0e0f);
        check("aes_kat", aes_enc(128'h00112233445566778899aabbccddeeff), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        expand(rnd128());
        for (int r = 0; r < 11; r++) aes_key[128*r +: 128] = rk[r];
        gr = rnd128() | 128'h1;
        cid = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_raw(XORGATE, 32'd7, {2{64'h0123456789abcdef}}, {{120{1'b1}}, 8'h00}, rnd128(), rnd128(),
                  {2{64'h0123456789abcdef}} ^ {{120{1'b1}}, 8'h00});
        idle(NR_AES + 2);
        drive_raw(NOTGATE, 32'd8, {16{8'hA5}}, rnd128(), rnd128(), rnd128(), {16{8'hA5}});
        idle(3);
        a0 = rnd128();
        b0 = rnd128();
        for (int ab = 0; ab < 4; ab++) drive_gate(ANDGATE, 32'd20, a0, b0, ab[1], ab[0]);
        idle(NR_AES + 2);
        cid = $urandom;
        do_reset(2);
        for (int i = 0; i < 11; i++) drive_gate(mix[i], 32'(i), rnd128(), rnd128(), 1'($urandom), 1'($urandom));
        idle(NR_AES + 3);
`ifdef GC_EVAL_STATS_EN
        check("free_count", 128'(free_count), 128'(4));
        check("table_count", 128'(table_count), 128'(7));
`endif
        for (int i = 0; i < 5; i++) drive_gate(codes[$urandom_range(0, 6)], 32'(40 + i), rnd128(), rnd128(), 1'($urandom), 1'($urandom));
        do_reset(1);
        drive_gate(ANDGATE, 32'd99, rnd128(), rnd128(), 1'b1, 1'b1);
        idle(NR_AES + 3);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) drive_gate(codes[$urandom_range(0, 6)], $urandom, rnd128(), rnd128(), 1'($urandom), 1'($urandom));
            else idle(1);
        end
        idle(NR_AES + 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gc_evaluator.md
GC_EVALUATOR -- requirements
Module: GC_evaluator

Interface
REQ-001 The block SHALL have parameter K, default 128, meaning wire-label width in bits.
REQ-002 The block SHALL have parameter S, default 32, meaning width of circuit id and gate id.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: AES_expandedKey  in  128*(NR_AES+1)  fixed-key AES schedule, the same schedule the garbler uses.
REQ-007 Port: cid  in  S  circuit id, sampled with each gate.
REQ-008 Port: in_valid  in  1  a gate is presented this cycle.
REQ-009 Port: gid  in  S  gate id.
REQ-010 Port: g_logic  in  4  gate truth-table code; XORGATE, XNORGATE and NOTGATE are free gates.
REQ-011 Port: in0_label, in1_label  in  K each  active input labels.
REQ-012 Port: gt_row_0, gt_row_1  in  K each  half-gate table rows TG, TE; ignored for free gates.
REQ-013 Port: out_valid  out  1  out_label and out_gid are valid.
REQ-014 Port: out_gid  out  S  gid of the emitted gate.
REQ-015 Port: out_label  out  K  active output label.

Function
REQ-016 Hash: H(W,t) = AES_k(2W ^ t) ^ (2W ^ t), where 2W is W shifted left by 1 in GF(2^K) doubling with the MSB dropped, and t = {cid, gid, b} zero-extended to K.
REQ-017 For non-free gates, let sa = in0_label[0] and sb = in1_label[0].
REQ-018 Non-free gates SHALL compute out = H(in0,{cid,gid,0}) ^ (sa ? gt_row_0 : 0) ^ H(in1,{cid,gid,1}) ^ (sb ? (gt_row_1 ^ in0) : 0).
REQ-019 XOR and XNOR gates SHALL compute out = in0_label ^ in1_label; NOT gates SHALL compute out = in0_label, because the garbler absorbs inversion.
REQ-020 Latency SHALL be exactly NR_AES+1 cycles from an in_valid sample to the matching out_valid, for all gate types.
REQ-021 Throughput SHALL be one gate per cycle with no backpressure; gates are emitted in input order.
REQ-022 Side-band data (gid, sa, sb, rows, in0, the free flag and the free result) SHALL ride a delay line aligned to the AES pipeline.
REQ-023 A bubble (in_valid=0) SHALL propagate as out_valid=0; out_label and out_gid hold their last value during bubbles.

Reset
REQ-024 While rst=1 on a rising edge, the block SHALL clear all pipeline valid bits; out_valid=0, out_label=0 and out_gid=0 on the next cycle.
REQ-025 Reset mid-operation SHALL discard every in-flight gate; none emerge after reset deasserts.
REQ-026 The first in_valid accepted in the cycle after reset deasserts SHALL appear NR_AES+1 cycles later.

Configuration
REQ-027 With GC_EVAL_STATS_EN defined, the block SHALL add outputs free_count and table_count, each 32 bits.
REQ-028 free_count and table_count SHALL count emitted free and non-free gates, saturate at 2^32-1, and clear on rst.
REQ-029 Without GC_EVAL_STATS_EN, these ports and counters SHALL not exist.

Structure
REQ-030 The gate-type codes, K/S defaults and NR_AES SHALL come from the shared MAC_H.vh header; the evaluator adds no new global constants.
REQ-031 One sub-module, GC_eval_hash, SHALL implement the two parallel pipelined fixed-key AES MMO hashes with latency NR_AES+1.
REQ-032 All other logic (tweak build, delay line, final combine) SHALL be inline in GC_evaluator.

Verification
REQ-033 XOR gate, in0=0x0123..ef, in1=0xffff..00 -> out_label = in0^in1 exactly NR_AES+1 cycles later, out_gid matches.
REQ-034 NOT gate, in0=0xA5..A5 -> out_label = 0xA5..A5 after NR_AES+1 cycles.
REQ-035 AND gate garbled by GC_engine (same R, AES key, cid, gid), evaluated with each of the 4 input-label combinations -> out equals the garbler's zero label, or zero label ^ R only for input (1,1).
REQ-036 Eleven back-to-back mixed gates (gid 0..10) -> eleven consecutive out_valid cycles in order, each matching the garbler-derived label.
REQ-037 rst pulsed while 5 gates are in flight -> no out_valid after reset; a new gate is accepted and emitted at NR_AES+1 cycles.
REQ-038 With GC_EVAL_STATS_EN, the REQ-036 stream of 4 free and 7 non-free gates -> free_count=4, table_count=7.
